// File: rtl/rans_interleaved_encoder_pkg.sv
// Shared definitions for the interleaved rANS encoder: state geometry,
// output word width and the controller state encoding.
package RansPackage;

    localparam int          STATE_WIDTH = 32;
    localparam int          OUT_WIDTH   = 16;
    localparam logic [31:0] L           = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RENORM,
        ST_DIVIDE,
        ST_UPDATE,
        ST_FLUSH_LO,
        ST_FLUSH_HI
    } rans_state_e;

endpackage

// File: rtl/rans_interleaved_encoder_divider.sv
// Serial restoring divider: one quotient bit per cycle, 32 cycles per
// division. start loads the operands; done pulses for one cycle when the
// quotient/remainder outputs are valid (they stay valid until next start).
module rans_serial_divider
    import RansPackage::*;
#(
    parameter int DIVISOR_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [STATE_WIDTH-1:0]   dividend,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic                     done,
    output logic [STATE_WIDTH-1:0]   quotient,
    output logic [DIVISOR_WIDTH-1:0] remainder
);

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [4:0]               count_q, count_d;
    logic [STATE_WIDTH-1:0]   quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0] rem_q, rem_d;
    logic [DIVISOR_WIDTH-1:0] divisor_q, divisor_d;
    logic [DIVISOR_WIDTH:0]   trial;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        trial     = {rem_q, quo_q[STATE_WIDTH-1]};
        if (start) begin
            busy_d    = 1'b1;
            count_d   = '0;
            quo_d     = dividend;
            rem_d     = '0;
            divisor_d = divisor;
        end else if (busy_q) begin
            if (trial >= {1'b0, divisor_q}) begin
                rem_d = DIVISOR_WIDTH'(trial - {1'b0, divisor_q});
                quo_d = {quo_q[STATE_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[DIVISOR_WIDTH-1:0];
                quo_d = {quo_q[STATE_WIDTH-2:0], 1'b0};
            end
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers; reset abandons any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/rans_interleaved_encoder.sv
// Interleaved rANS encoder: NUM_STREAMS lanes share one frequency table and
// one serial divider; symbols are dealt round-robin across the lanes and a
// block end flushes every lane as two 16-bit words (low then high).
// Optional feature: define RANS_ENC_FREQ_CHECK_EN to drop symbols whose
// table entry is inconsistent and raise a sticky err flag.
module rans_interleaved_encoder
    import RansPackage::*;
#(
    parameter  int RESOLUTION   = 10,
    parameter  int SYMBOL_WIDTH = 8,
    parameter  int NUM_STREAMS  = 4,
    localparam int LW           = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tbl_we,
    input  logic [SYMBOL_WIDTH-1:0] tbl_addr,
    input  logic [RESOLUTION:0]     tbl_freq,
    input  logic [RESOLUTION-1:0]   tbl_cum,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic [SYMBOL_WIDTH-1:0] sym_data,
    input  logic                    sym_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [LW-1:0]           out_stream,
    output logic                    out_last,
    output logic                    err
);

    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_STREAMS - 1);
    // Renormalisation bound per unit of frequency, kept in 33 bits so that
    // freq == 2^RESOLUTION gives 2^32 and can never be reached by x.
    localparam logic [32:0]   XMAX_UNIT = (33'(L) >> RESOLUTION) << 16;

    rans_state_e            state_q, state_d;
    logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
    logic [LW-1:0]          flush_lane_q, flush_lane_d;
    logic                   last_q, last_d;
    logic [STATE_WIDTH-1:0] lane_x_q [NUM_STREAMS];
    logic [STATE_WIDTH-1:0] lane_x_d [NUM_STREAMS];

    logic [RESOLUTION:0]     freq_mem [2**SYMBOL_WIDTH];
    logic [RESOLUTION-1:0]   cum_mem  [2**SYMBOL_WIDTH];
    logic [RESOLUTION:0]     freq_q;
    logic [RESOLUTION-1:0]   cum_q;

    logic                   sym_fire;
    logic [STATE_WIDTH-1:0] cur_x;
    logic [STATE_WIDTH-1:0] flush_x;
    logic [32:0]            x_max;
    logic                   need_emit;

    logic                   div_start;
    logic [STATE_WIDTH-1:0] div_dividend;
    logic                   div_done;
    logic [STATE_WIDTH-1:0] div_quo;
    logic [RESOLUTION:0]    div_rem;

`ifdef RANS_ENC_FREQ_CHECK_EN
    localparam logic [RESOLUTION+1:0] SCALE = (RESOLUTION+2)'(1) << RESOLUTION;
    logic                  err_q, err_d;
    logic [RESOLUTION+1:0] span;
    logic                  entry_bad;
    assign span      = (RESOLUTION+2)'(cum_q) + (RESOLUTION+2)'(freq_q);
    assign entry_bad = (freq_q == '0) || (span > SCALE);
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    assign sym_ready = (state_q == ST_IDLE);
    assign sym_fire  = sym_valid && sym_ready;
    assign cur_x     = lane_x_q[lane_cnt_q];
    assign flush_x   = lane_x_q[flush_lane_q];
    assign x_max     = XMAX_UNIT * 33'(freq_q);
    assign need_emit = {1'b0, cur_x} >= x_max;

    // Frequency table: write lands at the edge, read is registered when a
    // symbol is accepted, so a same-cycle write is not yet visible.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            freq_mem[tbl_addr] <= tbl_freq;
            cum_mem[tbl_addr]  <= tbl_cum;
        end
        if (sym_fire) begin
            freq_q <= freq_mem[sym_data];
            cum_q  <= cum_mem[sym_data];
        end
    end

    rans_serial_divider #(
        .DIVISOR_WIDTH (RESOLUTION + 1)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (freq_q),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Controller next-state, lane-state update and output word selection.
    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        flush_lane_d = flush_lane_q;
        last_d       = last_q;
        lane_x_d     = lane_x_q;
        div_start    = 1'b0;
        div_dividend = cur_x;
        out_valid    = 1'b0;
        out_data     = '0;
        out_stream   = '0;
        out_last     = 1'b0;
`ifdef RANS_ENC_FREQ_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sym_fire) begin
                    last_d  = sym_last;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
`ifdef RANS_ENC_FREQ_CHECK_EN
                if (entry_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RENORM;
                end
`else
                state_d = ST_RENORM;
`endif
            end
            ST_RENORM: begin
                if (need_emit) begin
                    out_valid  = 1'b1;
                    out_data   = cur_x[OUT_WIDTH-1:0];
                    out_stream = lane_cnt_q;
                    if (out_ready) begin
                        lane_x_d[lane_cnt_q] = cur_x >> OUT_WIDTH;
                        div_dividend         = cur_x >> OUT_WIDTH;
                        div_start            = 1'b1;
                        state_d              = ST_DIVIDE;
                    end
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                lane_x_d[lane_cnt_q] = (div_quo << RESOLUTION) + STATE_WIDTH'(div_rem)
                                     + STATE_WIDTH'(cum_q);
                lane_cnt_d = (lane_cnt_q == LAST_LANE) ? '0 : lane_cnt_q + 1'b1;
                if (last_q) begin
                    flush_lane_d = '0;
                    state_d      = ST_FLUSH_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_LO: begin
                out_valid  = 1'b1;
                out_data   = flush_x[OUT_WIDTH-1:0];
                out_stream = flush_lane_q;
                if (out_ready) begin
                    state_d = ST_FLUSH_HI;
                end
            end
            ST_FLUSH_HI: begin
                out_valid  = 1'b1;
                out_data   = flush_x[STATE_WIDTH-1:OUT_WIDTH];
                out_stream = flush_lane_q;
                out_last   = (flush_lane_q == LAST_LANE);
                if (out_ready) begin
                    if (flush_lane_q == LAST_LANE) begin
                        for (int i = 0; i < NUM_STREAMS; i++) begin
                            lane_x_d[i] = L;
                        end
                        lane_cnt_d   = '0;
                        flush_lane_d = '0;
                        last_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        flush_lane_d = flush_lane_q + 1'b1;
                        state_d      = ST_FLUSH_LO;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and lane-state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lane_cnt_q   <= '0;
            flush_lane_q <= '0;
            last_q       <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                lane_x_q[i] <= L;
            end
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            flush_lane_q <= flush_lane_d;
            last_q       <= last_d;
            lane_x_q     <= lane_x_d;
        end
    end

`ifdef RANS_ENC_FREQ_CHECK_EN
    // Sticky table-consistency flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_rans_interleaved_encoder.sv
// Directed bench for rans_interleaved_encoder (default parameters).
module tb_rans_interleaved_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tbl_we = 1'b0;
    logic [7:0]  tbl_addr = '0;
    logic [10:0] tbl_freq = '0;
    logic [9:0]  tbl_cum = '0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [7:0]  sym_data = '0;
    logic        sym_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_stream;
    logic        out_last;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    rans_interleaved_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_freq   (tbl_freq),
        .tbl_cum    (tbl_cum),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_stream (out_stream),
        .out_last   (out_last),
        .err        (err)
    );

    // Inputs change just after posedge, so a handshake seen at negedge
    // completes at the following posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_last, out_stream, out_data});
            $display("out word: data=%04h stream=%0d last=%0b", out_data, out_stream, out_last);
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] pack_word(input logic last, input logic [1:0] stream,
                                              input logic [15:0] data);
        return {last, stream, data};
    endfunction

    task automatic push_flush(input int lane, input logic [31:0] x);
        exp_q.push_back(pack_word(1'b0, 2'(lane), x[15:0]));
        exp_q.push_back(pack_word(lane == 3, 2'(lane), x[31:16]));
    endtask

    task automatic push_idle_lanes(input int first);
        for (int i = first; i < 4; i++) push_flush(i, 32'h0001_0000);
    endtask

    task automatic write_tbl(input logic [7:0] a, input logic [10:0] f, input logic [9:0] c);
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_addr = a; tbl_freq = f; tbl_cum = c;
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic last);
        bit taken = 0;
        @(posedge clk); #1;
        sym_valid = 1'b1; sym_data = d; sym_last = last;
        for (int c = 0; c < 500 && !taken; c++) begin
            @(negedge clk);
            if (sym_ready) begin
                @(posedge clk); #1;
                taken = 1;
            end
        end
        sym_valid = 1'b0; sym_last = 1'b0;
        if (!taken) check_vec("sym accept timeout", 0, 1);
    endtask

    // Waits for the expected word count, then compares word by word.
    task automatic check_words(input string tag);
        int n = exp_q.size();
        for (int c = 0; c < 3000 && got_q.size() < n; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_vec({tag, " count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) check_vec($sformatf("%s w%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_vec("reset out_valid", out_valid, 0);
        check_vec("reset err", err, 0);
        check_vec("reset sym_ready", sym_ready, 1);

        write_tbl(8'h00, 11'd1024, 10'd0);   // identity entry
        write_tbl(8'h41, 11'd512, 10'd512);
        write_tbl(8'h07, 11'd1, 10'd0);
        write_tbl(8'h10, 11'd3, 10'd5);

        // Block end with an identity symbol: every lane flushes its initial state.
        send_sym(8'h00, 1'b1);
        push_idle_lanes(0);
        check_words("flush initial");

        // Half-probability symbol on lane 0, no renormalisation.
        send_sym(8'h41, 1'b1);
        push_flush(0, 32'h0002_0200);
        push_idle_lanes(1);
        check_words("sym41");

        // freq=1: four lanes grow to 0x0400_0000, fifth symbol renormalises lane 0.
        for (int i = 0; i < 4; i++) send_sym(8'h07, 1'b0);
        send_sym(8'h07, 1'b1);
        exp_q.push_back(pack_word(1'b0, 2'd0, 16'h0000));
        push_flush(0, 32'h0010_0000);
        for (int i = 1; i < 4; i++) push_flush(i, 32'h0400_0000);
        check_words("renorm");

        // Table write in the same cycle as the symbol: old entry (3,5) is used,
        // the next symbol sees the new identity entry.
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_addr = 8'h10; tbl_freq = 11'd1024; tbl_cum = 10'd0;
        sym_valid = 1'b1; sym_data = 8'h10; sym_last = 1'b0;
        @(negedge clk);
        check_vec("same-cycle sym_ready", sym_ready, 1);
        @(posedge clk); #1;
        tbl_we = 1'b0; sym_valid = 1'b0;
        send_sym(8'h10, 1'b1);
        push_flush(0, 32'h0155_5406);
        push_idle_lanes(1);
        check_words("tbl same cycle");

        // Back-pressure during flush: first word must hold steady.
        out_ready = 1'b0;
        send_sym(8'h41, 1'b1);
        for (int c = 0; c < 200 && !out_valid; c++) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            check_vec($sformatf("stall c%0d", c),
                      {out_valid, out_last, out_stream, out_data, sym_ready},
                      {1'b1, 1'b0, 2'd0, 16'h0200, 1'b0});
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        push_flush(0, 32'h0002_0200);
        push_idle_lanes(1);
        check_words("stall");

        // Reset in the middle of a division abandons the block and
        // restores lane states and the lane counter.
        send_sym(8'h07, 1'b0);
        send_sym(8'h41, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        check_vec("abandon no words", got_q.size(), 0);
        check_vec("abandon out_valid", out_valid, 0);
        send_sym(8'h41, 1'b1);
        push_flush(0, 32'h0002_0200);
        push_idle_lanes(1);
        check_words("after reset");

`ifdef RANS_ENC_FREQ_CHECK_EN
        // Zero-frequency entry is dropped and flags err until reset.
        write_tbl(8'h20, 11'd0, 10'd0);
        send_sym(8'h20, 1'b0);
        repeat (10) @(negedge clk);
        check_vec("err set", err, 1);
        send_sym(8'h41, 1'b1);
        push_flush(0, 32'h0002_0200);
        push_idle_lanes(1);
        check_words("err lane kept");
        check_vec("err sticky", err, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_vec("err cleared", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
